// File: rtl/vga_frame_reader.sv
// vga_frame_reader: generates 640x480@60 VGA timing from a 50 MHz clock, fetches
// the 256x256 8bpp framebuffer window through a synchronous read port and drives
// RGB plus active-low syncs through a two-tick pipeline so that all pins stay aligned.
module vga_frame_reader #(
   parameter int          H_VISIBLE    = 640,
   parameter int          H_FRONT      = 16,
   parameter int          H_SYNC       = 96,
   parameter int          H_BACK       = 48,
   parameter int          V_VISIBLE    = 480,
   parameter int          V_FRONT      = 10,
   parameter int          V_SYNC       = 2,
   parameter int          V_BACK       = 33,
   parameter int          WIN_X0       = 192,
   parameter int          WIN_Y0       = 112,
   parameter logic [7:0]  BORDER_COLOR = 8'h00
) (
   input  logic        Clock,
   input  logic        Reset,
   output logic [15:0] oReadAddress,
   input  logic [7:0]  iReadData,
   output logic [7:0]  oVGA_RGB,
   output logic        oVGA_HSYNC,
   output logic        oVGA_VSYNC,
   output logic        oFrameStart
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0]  L_H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0]  L_V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0]  L_H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0]  L_V_VIS      = 10'(V_VISIBLE);
   localparam logic [9:0]  L_HS_START   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0]  L_HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0]  L_VS_START   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0]  L_VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [10:0] L_WIN_X0     = 11'(WIN_X0);
   localparam logic [10:0] L_WIN_X1     = 11'(WIN_X0 + 256);
   localparam logic [10:0] L_WIN_Y0     = 11'(WIN_Y0);
   localparam logic [10:0] L_WIN_Y1     = 11'(WIN_Y0 + 256);
   localparam logic [7:0]  L_WIN_X0_LO  = 8'(WIN_X0);
   localparam logic [7:0]  L_WIN_Y0_LO  = 8'(WIN_Y0);

   logic        r_pe;
   logic [9:0]  r_hcount;
   logic [9:0]  r_vcount;

   logic        w_tick;
   logic        w_hsync_raw;
   logic        w_vsync_raw;
   logic        w_visible_raw;
   logic        w_inwin_raw;
   logic        w_first_raw;
   logic [7:0]  w_row;
   logic [7:0]  w_col;

   logic [15:0] r_read_address;
   logic        r_s1_hsync;
   logic        r_s1_vsync;
   logic        r_s1_visible;
   logic        r_s1_inwin;
   logic        r_s1_first;

   logic [7:0]  r_rgb;
   logic        r_hsync;
   logic        r_vsync;
   logic        r_frame_start;

   // Decode raw sync/visibility/window flags and the window-relative address from the counters.
   always_comb begin
      w_tick        = ~r_pe;
      w_hsync_raw   = ~((r_hcount >= L_HS_START) && (r_hcount < L_HS_END));
      w_vsync_raw   = ~((r_vcount >= L_VS_START) && (r_vcount < L_VS_END));
      w_visible_raw = (r_hcount < L_H_VIS) && (r_vcount < L_V_VIS);
      w_inwin_raw   = w_visible_raw
                      && ({1'b0, r_hcount} >= L_WIN_X0) && ({1'b0, r_hcount} < L_WIN_X1)
                      && ({1'b0, r_vcount} >= L_WIN_Y0) && ({1'b0, r_vcount} < L_WIN_Y1);
      w_first_raw   = (r_hcount == 10'd0) && (r_vcount == 10'd0);
      // Truncated arithmetic: outside the window this wraps but stays deterministic.
      w_row         = r_vcount[7:0] - L_WIN_Y0_LO;
      w_col         = r_hcount[7:0] - L_WIN_X0_LO;
   end

   // Pixel-enable toggle and horizontal/vertical counters advancing on each pixel tick.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_pe     <= 1'b0;
         r_hcount <= 10'd0;
         r_vcount <= 10'd0;
      end else begin
         r_pe <= ~r_pe;
         if (w_tick) begin
            if (r_hcount == L_H_LAST) begin
               r_hcount <= 10'd0;
               if (r_vcount == L_V_LAST) begin
                  r_vcount <= 10'd0;
               end else begin
                  r_vcount <= r_vcount + 10'd1;
               end
            end else begin
               r_hcount <= r_hcount + 10'd1;
            end
         end
      end
   end

   // Stage 0: issue the RAM read address and capture the timing flags for this pixel.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_read_address <= 16'h0000;
         r_s1_hsync     <= 1'b1;
         r_s1_vsync     <= 1'b1;
         r_s1_visible   <= 1'b0;
         r_s1_inwin     <= 1'b0;
         r_s1_first     <= 1'b0;
      end else if (w_tick) begin
         r_read_address <= {w_row, w_col};
         r_s1_hsync     <= w_hsync_raw;
         r_s1_vsync     <= w_vsync_raw;
         r_s1_visible   <= w_visible_raw;
         r_s1_inwin     <= w_inwin_raw;
         r_s1_first     <= w_first_raw;
      end
   end

   // Stage 1: select pixel colour and drive syncs in step with the returned RAM data.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_rgb         <= 8'h00;
         r_hsync       <= 1'b1;
         r_vsync       <= 1'b1;
         r_frame_start <= 1'b0;
      end else if (w_tick) begin
         if (r_s1_inwin) begin
            r_rgb <= iReadData;
         end else if (r_s1_visible) begin
            r_rgb <= BORDER_COLOR;
         end else begin
            r_rgb <= 8'h00;
         end
         r_hsync       <= r_s1_hsync;
         r_vsync       <= r_s1_vsync;
         r_frame_start <= r_s1_first;
      end else begin
         // Frame-start is a single-Clock pulse, so it drops on the off-tick Clock.
         r_frame_start <= 1'b0;
      end
   end

   assign oReadAddress = r_read_address;
   assign oVGA_RGB     = r_rgb;
   assign oVGA_HSYNC   = r_hsync;
   assign oVGA_VSYNC   = r_vsync;
   assign oFrameStart  = r_frame_start;

endmodule
